// File: rtl/mac_vector_pkg.sv
// Shared types and helpers for the multi-lane MAC (mac_vector).
package mac_vector_pkg;

  // Control FSM states; IDLE encodes as zero so a cleared state register means IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } mac_vector_state_t;

  localparam int unsigned STATE_W = 2;

  // Width of a counter able to hold 0..max_len inclusive.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/mac_vector_if.sv
// Job, operand and result handshake bundle for mac_vector.
interface mac_vector_if #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned MAX_LEN   = 256
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned SH_W  = $clog2(ACC_WIDTH);

  // job control, sampled with start
  logic                         start_i;
  logic [LEN_W-1:0]             len_i;
  logic [SH_W-1:0]              shift_i;
  logic                         seed_en_i;
  logic [LANES*ACC_WIDTH-1:0]   psum_in_i;
  // operand beats
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [LANES*A_WIDTH-1:0]     a_i;
  logic [LANES*B_WIDTH-1:0]     b_i;
  // results
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [LANES*OUT_WIDTH-1:0]   out_o;
  logic [LANES*ACC_WIDTH-1:0]   out_acc_o;
  logic [LANES-1:0]             sat_o;
  logic                         busy_o;

  modport master (
    output start_i, len_i, shift_i, seed_en_i, psum_in_i,
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_o, out_acc_o, sat_o, busy_o
  );

  modport slave (
    input  start_i, len_i, shift_i, seed_en_i, psum_in_i,
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, out_o, out_acc_o, sat_o, busy_o
  );

endinterface

// File: rtl/mac_requant.sv
// Per-lane requantiser: round-half-up, arithmetic right shift, saturate.
module mac_requant #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SH_W      = $clog2(ACC_WIDTH)
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic        [SH_W-1:0]      shift_i,
  output logic signed [OUT_WIDTH-1:0] q_o,
  output logic                        sat_o
);
  // One extra bit so adding the rounding constant can never overflow.
  localparam int unsigned RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] MAX_C = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MIN_C = RW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  logic signed [RW-1:0] ext_s;
  logic signed [RW-1:0] rnd_s;
  logic signed [RW-1:0] sum_s;
  logic signed [RW-1:0] shr_s;

  assign ext_s = RW'(acc_i);
  assign sum_s = ext_s + rnd_s;
  assign shr_s = sum_s >>> shift_i;

  // Rounding constant is half an output LSB, none when there is no shift.
  always_comb begin
    rnd_s = '0;
    if (shift_i == '0) begin
      rnd_s = '0;
    end else begin
      rnd_s = RW'(1) << (shift_i - SH_W'(1));
    end
  end

  // Clamp to the signed output range and flag when the clamp bites.
  always_comb begin
    q_o   = '0;
    sat_o = 1'b0;
    if (shr_s > MAX_C) begin
      q_o   = MAX_C[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end else if (shr_s < MIN_C) begin
      q_o   = MIN_C[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end else begin
      q_o   = shr_s[OUT_WIDTH-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/mac_vector_reg.sv
// Shared enable-gated register with asynchronous active-low reset.
module mac_vector_reg #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when enabled; reset clears to RST_VAL immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mac_vector.sv
// LANES signed multiply-accumulate lanes sharing one length counter and
// control FSM, with per-lane requantisation behind a valid/ready output.
module mac_vector
  import mac_vector_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic       clk,
  input  logic       arst_n,
  mac_vector_if.slave bus
);
  localparam int unsigned LEN_W = len_width(MAX_LEN);
  localparam int unsigned SH_W  = $clog2(ACC_WIDTH);
  localparam int unsigned P_W   = A_WIDTH + B_WIDTH;

  logic [STATE_W-1:0]  state_raw_q;
  mac_vector_state_t   state_q;
  mac_vector_state_t   state_d;
  logic [LEN_W-1:0]    count_q;
  logic [LEN_W-1:0]    count_d;
  logic [SH_W-1:0]     shift_q;
  logic                start_fire_s;
  logic                beat_fire_s;
  logic                out_fire_s;
  logic                acc_we_s;

  logic signed [ACC_WIDTH-1:0] acc_vec_s [LANES];
  logic signed [OUT_WIDTH-1:0] q_vec_s   [LANES];
  logic                        sat_vec_s [LANES];

  assign state_q      = mac_vector_state_t'(state_raw_q);
  assign start_fire_s = (state_q == IDLE)  && bus.start_i;
  assign beat_fire_s  = (state_q == ACCUM) && bus.in_valid_i;
  assign out_fire_s   = (state_q == OUT)   && bus.out_ready_i;
  assign acc_we_s     = start_fire_s || beat_fire_s;

  // Handshake flags decode the registered state only, never in_valid/out_ready.
  assign bus.in_ready_o  = (state_q == ACCUM);
  assign bus.out_valid_o = (state_q == OUT);
  assign bus.busy_o      = (state_q != IDLE);

  // FSM next state: a zero-length job skips straight to OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i == '0) begin
            state_d = OUT;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat_fire_s && (count_q == LEN_W'(1))) begin
          state_d = OUT;
        end else begin
          state_d = ACCUM;
        end
      end
      OUT: begin
        if (out_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Remaining-beats counter: loaded on start, decremented per accepted beat.
  always_comb begin
    count_d = count_q;
    if (start_fire_s) begin
      count_d = bus.len_i;
    end else begin
      count_d = count_q - LEN_W'(1);
    end
  end

  mac_vector_reg #(.W(STATE_W)) u_state_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (1'b1),
    .d      (state_d),
    .q      (state_raw_q)
  );

  mac_vector_reg #(.W(LEN_W)) u_count_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (acc_we_s),
    .d      (count_d),
    .q      (count_q)
  );

  mac_vector_reg #(.W(SH_W)) u_shift_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (start_fire_s),
    .d      (bus.shift_i),
    .q      (shift_q)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [A_WIDTH-1:0]   a_s;
    logic signed [B_WIDTH-1:0]   b_s;
    logic signed [P_W-1:0]       prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] seed_s;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;

    assign a_s        = bus.a_i[gi*A_WIDTH +: A_WIDTH];
    assign b_s        = bus.b_i[gi*B_WIDTH +: B_WIDTH];
    assign seed_s     = bus.psum_in_i[gi*ACC_WIDTH +: ACC_WIDTH];
    assign prod_s     = P_W'(a_s) * P_W'(b_s);
    assign prod_ext_s = ACC_WIDTH'(prod_s);

    // Seed in IDLE, otherwise add the sign-extended product (wraps freely).
    always_comb begin
      acc_d = acc_q;
      if (state_q == IDLE) begin
        if (bus.seed_en_i) begin
          acc_d = seed_s;
        end else begin
          acc_d = '0;
        end
      end else begin
        acc_d = acc_q + prod_ext_s;
      end
    end

    mac_vector_reg #(.W(ACC_WIDTH)) u_acc_reg (
      .clk    (clk),
      .arst_n (arst_n),
      .we     (acc_we_s),
      .d      (acc_d),
      .q      (acc_q)
    );

    assign acc_vec_s[gi] = acc_q;

    mac_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SH_W      (SH_W)
    ) u_requant (
      .acc_i   (acc_q),
      .shift_i (shift_q),
      .q_o     (q_vec_s[gi]),
      .sat_o   (sat_vec_s[gi])
    );
  end

  // Pack per-lane results onto the flat result buses.
  always_comb begin
    bus.out_o     = '0;
    bus.out_acc_o = '0;
    bus.sat_o     = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.out_o[i*OUT_WIDTH +: OUT_WIDTH]     = q_vec_s[i];
      bus.out_acc_o[i*ACC_WIDTH +: ACC_WIDTH] = acc_vec_s[i];
      bus.sat_o[i]                            = sat_vec_s[i];
    end
  end

endmodule

// File: tb/tb_mac_vector.sv
// Randomised self-checking bench for mac_vector against a dot-product model.
module tb_mac_vector;
  localparam int LANES = 4;
  localparam int AW    = 8;
  localparam int BW    = 8;
  localparam int ACCW  = 24;
  localparam int OW    = 8;
  localparam int MAXL  = 256;
  localparam int LW    = $clog2(MAXL + 1);
  localparam int SW    = $clog2(ACCW);

  logic clk;
  logic arst_n;
  int   n_cmp;
  int   n_mis;

  logic [LANES*AW-1:0] a_beats[$];
  logic [LANES*BW-1:0] b_beats[$];
  longint last_acc [LANES];
  longint last_q   [LANES];
  longint last_s   [LANES];

  mac_vector_if #(
    .LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW),
    .ACC_WIDTH(ACCW), .OUT_WIDTH(OW), .MAX_LEN(MAXL)
  ) bus ();

  mac_vector #(
    .LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW),
    .ACC_WIDTH(ACCW), .OUT_WIDTH(OW), .MAX_LEN(MAXL)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*AW-1:0] pk8(input int v0, input int v1, input int v2, input int v3);
    return {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  function automatic logic [LANES*ACCW-1:0] pk24(input int v0, input int v1, input int v2, input int v3);
    return {v3[23:0], v2[23:0], v1[23:0], v0[23:0]};
  endfunction

  // Reduce an arbitrary integer to a signed ACCW-bit value (modulo wrap).
  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & ((64'sd1 <<< ACCW) - 64'sd1);
    if (m >= (64'sd1 <<< (ACCW - 1))) m = m - (64'sd1 <<< ACCW);
    return m;
  endfunction

  // Round half up, arithmetic shift, clamp to OW signed bits.
  function automatic longint requant(input longint acc, input int sh, output longint s);
    longint r;
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (OW - 1)) - 1;
    lo = -(64'sd1 <<< (OW - 1));
    r  = acc + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
    r  = r >>> sh;
    s  = 0;
    if (r > hi) begin r = hi; s = 1; end
    else if (r < lo) begin r = lo; s = 1; end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_in_ready"}, bus.in_ready_o, 0);
    chk({tag, "_out_valid"}, bus.out_valid_o, 0);
  endtask

  // One job: vmode 0=always valid, 1=valid pattern 1,0,0,1,1, 2=random valid.
  task automatic run_job(input int len, input int sh, input bit seed,
                         input logic [LANES*ACCW-1:0] psum, input int vmode, input int owait);
    longint exp_acc [LANES];
    longint exp_q   [LANES];
    longint exp_s   [LANES];
    logic signed [ACCW-1:0] pv;
    logic signed [AW-1:0]   av;
    logic signed [BW-1:0]   bv;
    logic signed [OW-1:0]   gq;
    logic signed [ACCW-1:0] ga;
    logic [LANES*AW-1:0]    avec;
    logic [LANES*BW-1:0]    bvec;
    logic [4:0]             pat;
    bit                     v;
    int                     idx;
    int                     cyc;
    pat = 5'b11001;
    chk("pre_start_busy", bus.busy_o, 0);
    bus.start_i    = 1'b1;
    bus.len_i      = len[LW-1:0];
    bus.shift_i    = sh[SW-1:0];
    bus.seed_en_i  = seed;
    bus.psum_in_i  = psum;
    bus.in_valid_i = 1'b1;
    bus.a_i        = $urandom;
    bus.b_i        = $urandom;
    for (int i = 0; i < LANES; i++) begin
      pv = psum[i*ACCW +: ACCW];
      exp_acc[i] = seed ? longint'(pv) : 64'sd0;
    end
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.seed_en_i = ~seed;
    bus.psum_in_i = {$urandom, $urandom, $urandom};
    bus.shift_i   = SW'($urandom);
    bus.len_i     = LW'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 300) begin
      chk("accum_in_ready", bus.in_ready_o, 1);
      chk("accum_out_valid", bus.out_valid_o, 0);
      chk("accum_busy", bus.busy_o, 1);
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = pat[cyc % 5];
      else v = ($urandom_range(0, 99) < 70);
      avec = (v && idx < a_beats.size()) ? a_beats[idx] : LANES*AW'($urandom);
      bvec = (v && idx < b_beats.size()) ? b_beats[idx] : LANES*BW'($urandom);
      bus.in_valid_i = v;
      bus.a_i = avec;
      bus.b_i = bvec;
      if (v) begin
        for (int i = 0; i < LANES; i++) begin
          av = avec[i*AW +: AW];
          bv = bvec[i*BW +: BW];
          exp_acc[i] = exp_acc[i] + longint'(av) * longint'(bv);
        end
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 300) chk("beat_budget_expired", 0, 1);
    // operand traffic while not accumulating must be ignored
    bus.in_valid_i = 1'b1;
    bus.a_i = $urandom;
    bus.b_i = $urandom;
    for (int i = 0; i < LANES; i++) begin
      exp_acc[i] = wrap_acc(exp_acc[i]);
      exp_q[i]   = requant(exp_acc[i], sh, exp_s[i]);
    end
    for (int w = 0; w <= owait; w++) begin
      chk("out_valid", bus.out_valid_o, 1);
      chk("out_in_ready", bus.in_ready_o, 0);
      chk("out_busy", bus.busy_o, 1);
      for (int i = 0; i < LANES; i++) begin
        ga = bus.out_acc_o[i*ACCW +: ACCW];
        gq = bus.out_o[i*OW +: OW];
        chk($sformatf("out_acc%0d", i), ga, exp_acc[i]);
        chk($sformatf("out%0d", i), gq, exp_q[i]);
        chk($sformatf("sat%0d", i), bus.sat_o[i], exp_s[i]);
        last_acc[i] = ga;
        last_q[i]   = gq;
        last_s[i]   = bus.sat_o[i];
      end
      bus.out_ready_i = (w == owait);
      bus.start_i     = (w < owait) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.len_i       = LW'($urandom_range(0, 4));
      @(negedge clk);
    end
    bus.out_ready_i = 1'b0;
    bus.start_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    check_idle_outputs("post_handshake");
    a_beats.delete();
    b_beats.delete();
  endtask

  initial begin
    logic [LANES*ACCW-1:0] ps;
    int sv [LANES];
    n_cmp = 0;
    n_mis = 0;
    arst_n = 1'b0;
    bus.start_i = 1'b0; bus.len_i = '0; bus.shift_i = '0; bus.seed_en_i = 1'b0;
    bus.psum_in_i = '0; bus.in_valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_out", bus.out_o, 0);
    chk("reset_out_acc", bus.out_acc_o, 0);
    chk("reset_sat", bus.sat_o, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // plain dot product, no seed, no shift
    repeat (3) begin a_beats.push_back(pk8(1, 2, 3, 4)); b_beats.push_back(pk8(5, 5, 5, 5)); end
    run_job(3, 0, 1'b0, '0, 0, 0);
    chk("t1_acc0", last_acc[0], 15); chk("t1_acc3", last_acc[3], 60);
    chk("t1_out2", last_q[2], 45);   chk("t1_sat1", last_s[1], 0);

    // seeded job with rounding shift
    a_beats.push_back(pk8(2, 2, 2, 2)); b_beats.push_back(pk8(2, 2, 2, 2));
    run_job(1, 2, 1'b1, pk24(100, -100, 0, 7), 0, 1);
    chk("t2_acc1", last_acc[1], -96);
    chk("t2_out0", last_q[0], 26); chk("t2_out1", last_q[1], -24);
    chk("t2_out2", last_q[2], 1);  chk("t2_out3", last_q[3], 3);

    // saturation both ways
    repeat (4) begin a_beats.push_back(pk8(127, -128, 127, 0)); b_beats.push_back(pk8(127, 127, 127, 0)); end
    run_job(4, 0, 1'b0, '0, 0, 0);
    chk("t3_out0", last_q[0], 127);  chk("t3_sat0", last_s[0], 1);
    chk("t3_out1", last_q[1], -128); chk("t3_sat1", last_s[1], 1);
    chk("t3_out3", last_q[3], 0);    chk("t3_sat3", last_s[3], 0);

    // stalled input, held output with ignored start pulses
    run_job(3, 1, 1'b0, '0, 1, 5);

    // zero-length seeded job
    run_job(0, 0, 1'b1, pk24(-5, 1000, 8388607, -8388608), 0, 0);
    chk("t5_acc1", last_acc[1], 1000); chk("t5_acc3", last_acc[3], -8388608);

    // reset mid-accumulation
    bus.start_i = 1'b1; bus.len_i = LW'(5); bus.seed_en_i = 1'b1;
    bus.psum_in_i = pk24(50, 50, 50, 50); bus.shift_i = '0;
    @(negedge clk);
    bus.start_i = 1'b0; bus.in_valid_i = 1'b1; bus.a_i = pk8(9, 9, 9, 9); bus.b_i = pk8(9, 9, 9, 9);
    repeat (2) @(negedge clk);
    bus.in_valid_i = 1'b0;
    arst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    chk("abort_out_acc", bus.out_acc_o, 0);
    chk("abort_out", bus.out_o, 0);
    chk("abort_sat", bus.sat_o, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    repeat (2) begin a_beats.push_back(pk8(3, -3, 1, 0)); b_beats.push_back(pk8(4, 4, -7, 9)); end
    run_job(2, 0, 1'b0, '0, 0, 0);
    chk("t6_acc0", last_acc[0], 24); chk("t6_acc1", last_acc[1], -24);
    chk("t6_acc2", last_acc[2], -14); chk("t6_acc3", last_acc[3], 0);

    // accumulator wrap-around
    repeat (3) begin a_beats.push_back(pk8(127, -128, 127, -128)); b_beats.push_back(pk8(127, 127, -128, -128)); end
    run_job(3, 4, 1'b1, pk24(8388000, -8388000, -8388000, 8388000), 2, 1);

    // randomised jobs
    for (int j = 0; j < 14; j++) begin
      for (int i = 0; i < LANES; i++) sv[i] = int'($urandom_range(0, 4194304)) - 2097152;
      ps = pk24(sv[0], sv[1], sv[2], sv[3]);
      run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
              ps, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
